mdu_sched: RTL and testbench

Sequencing controller for the EXE-stage multiply/divide resources. It accepts one MDU operation at a time from the EXE stage and launches it on the shared fixed-latency multiplier or the handshaked iterative divider. It raises the EXE stall while the operation is in flight, accumulates for MADD/MSUB, and holds the 64-bit result until the pipeline commits it to HI/LO. It sits between the EXE pipeline register outputs and the HILO register file, replacing ad-hoc finish/stall wiring.

---
 rtl/mdu_sched_if.sv | 24 ++
 rtl/mdu_sched.sv | 72 +++++++
 tb/tb_mdu_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_sched_if.sv
// mdu_sched_if: EXE request, multiplier, divider and HI/LO commit signals of the MDU sequencer
interface mdu_sched_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, hi_in, lo_in;
  logic        flush, exe_wr;
  logic        mul_start, mul_signed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;
  logic        div_start, div_signed, div_abort, div_done;
  logic [31:0] div_a, div_b, div_q, div_r;
  logic        mdu_stall, res_valid, hilo_we;
  logic [31:0] res_hi, res_lo;
  modport slave (
    input  req_valid, req_op, req_a, req_b, hi_in, lo_in, flush, exe_wr, mul_p, div_done, div_q, div_r,
    output mul_start, mul_signed, mul_a, mul_b, div_start, div_signed, div_a, div_b, div_abort,
           mdu_stall, res_valid, res_hi, res_lo, hilo_we
  );
  modport master (
    output req_valid, req_op, req_a, req_b, hi_in, lo_in, flush, exe_wr, mul_p, div_done, div_q, div_r,
    input  mul_start, mul_signed, mul_a, mul_b, div_start, div_signed, div_a, div_b, div_abort,
           mdu_stall, res_valid, res_hi, res_lo, hilo_we
  );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched: launches one MDU op on the fixed-latency multiplier or iterative divider and holds the HI/LO result
module mdu_sched #(
  parameter int MUL_LAT = 2
) (
  input logic clk,
  input logic rst,
  mdu_sched_if.slave m
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d, cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d, res_q, res_d, mul_res;
  logic        wait_st, div_op, launch, kill, mul_cap, div_cap;
  always_comb begin
    wait_st = state_q == MUL_WAIT || state_q == DIV_WAIT;
    div_op  = m.req_op[2:1] == 2'b01;
    launch  = !rst && state_q == IDLE && m.req_valid && !m.flush;
    // losing req_valid while waiting means the instruction left EXE: same as a flush
    kill    = m.flush || (wait_st && !m.req_valid);
    mul_cap = state_q == MUL_WAIT && cnt_q == 3'd0 && !kill;
    div_cap = state_q == DIV_WAIT && m.div_done && !kill;
    mul_res = !op_q[2] ? m.mul_p : op_q[1] ? acc_q - m.mul_p : acc_q + m.mul_p;
    state_d = kill ? IDLE :
              launch ? (div_op ? DIV_WAIT : MUL_WAIT) :
              (mul_cap || div_cap) ? DONE :
              (state_q == DONE && m.exe_wr) ? IDLE : state_q;
    cnt_d   = launch ? 3'(MUL_LAT - 1) : (state_q == MUL_WAIT && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    op_d    = launch ? m.req_op : op_q;
    sgn_d   = launch ? !m.req_op[0] : sgn_q;
    a_d     = launch ? m.req_a : a_q;
    b_d     = launch ? m.req_b : b_q;
    acc_d   = launch ? {m.hi_in, m.lo_in} : acc_q;
    res_d   = mul_cap ? mul_res : div_cap ? {m.div_r, m.div_q} : res_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end
  assign m.mul_start  = launch && !div_op;
  assign m.div_start  = launch && div_op;
  assign m.mul_signed = launch ? !m.req_op[0] : sgn_q;
  assign m.div_signed = m.mul_signed;
  assign m.mul_a      = launch ? m.req_a : a_q;
  assign m.mul_b      = launch ? m.req_b : b_q;
  assign m.div_a      = m.mul_a;
  assign m.div_b      = m.mul_b;
  assign m.div_abort  = !rst && state_q == DIV_WAIT && kill;
  assign m.mdu_stall  = !rst && m.req_valid && !m.flush && state_q != DONE;
  assign m.res_valid  = state_q == DONE;
  assign m.hilo_we    = state_q == DONE && m.exe_wr && !m.flush;
  assign m.res_hi     = res_q[63:32];
  assign m.res_lo     = res_q[31:0];
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: table vectors, flush corner sequences and random ops against a transaction-level HI/LO model
module tb_mdu_sched;
  localparam int MUL_LAT = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mdu_sched_if m();
  mdu_sched #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .m(m));

  int checks = 0, errors = 0;
  int cyc = 0, ml_cyc = -100, dcnt = 0, dlat = 1;
  logic [63:0] ml_p = '0;
  logic [31:0] dq = '0, dr = '0;
  logic stray = 1'b0;

  function automatic logic [63:0] mul64(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // divider convention for b==0: quotient all ones, remainder = dividend
  function automatic logic [63:0] div64(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    return s ? {32'(sa % sb), 32'(sa / sb)} : {a % b, a / b};
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    if (op == 3'd2 || op == 3'd3) return div64(op == 3'd2, a, b);
    if (op <= 3'd1) return mul64(op == 3'd0, a, b);
    if (op <= 3'd5) return {hi, lo} + mul64(op == 3'd4, a, b);
    return {hi, lo} - mul64(op == 3'd6, a, b);
  endfunction

  // multiplier shows the product only in the one cycle it is guaranteed valid
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m.mul_start) begin
      ml_cyc <= cyc;
      ml_p   <= mul64(m.mul_signed, m.mul_a, m.mul_b);
    end
    if (m.div_start) begin
      dcnt <= dlat;
      {dr, dq} <= div64(m.div_signed, m.div_a, m.div_b);
    end else if (m.div_abort) dcnt <= 0;
    else if (dcnt > 0) dcnt <= dcnt - 1;
  end
  assign m.mul_p    = (cyc == ml_cyc + MUL_LAT) ? ml_p : ~ml_p;
  assign m.div_done = dcnt == 1 || stray;
  assign m.div_q    = dq;
  assign m.div_r    = dr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int dl, input int hold,
                        input int flush_at, input bit drop, input logic [63:0] exp);
    bit is_div;
    int n;
    is_div = op == 3'd2 || op == 3'd3;
    dlat = dl;
    m.req_valid = 1'b1; m.req_op = op; m.req_a = a; m.req_b = b;
    m.hi_in = hi; m.lo_in = lo; m.flush = 1'b0; m.exe_wr = 1'b0;
    #1;
    chk("launch_res_valid", m.res_valid, 0);
    chk("launch_hilo_we", m.hilo_we, 0);
    chk("launch_stall", m.mdu_stall, 1);
    chk("launch_pulse", {m.mul_start, m.div_start, m.div_abort}, is_div ? 3'b010 : 3'b100);
    chk("launch_opnd", is_div ? {m.div_a, m.div_b} : {m.mul_a, m.mul_b}, {a, b});
    chk("launch_sign", is_div ? m.div_signed : m.mul_signed, !op[0]);
    @(posedge clk); #1;
    m.hi_in = $urandom; m.lo_in = $urandom; m.req_a = $urandom; m.req_b = $urandom;
    n = 1;
    for (int i = 1; i <= 100; i++) begin
      if (i == flush_at) begin
        if (drop) m.req_valid = 1'b0;
        else m.flush = 1'b1;
        #1;
        chk("flush_abort", m.div_abort, is_div);
        chk("flush_stall", m.mdu_stall, 0);
        chk("flush_we", m.hilo_we, 0);
        @(posedge clk); #1;
        m.flush = 1'b0; m.req_valid = 1'b0; m.exe_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("flushed_res_valid", m.res_valid, 0);
          chk("flushed_we", m.hilo_we, 0);
          chk("flushed_pulses", {m.mul_start, m.div_start, m.div_abort}, 0);
          @(posedge clk); #1;
        end
        m.exe_wr = 1'b0;
        return;
      end
      #1;
      if (m.res_valid) break;
      chk("wait_stall", m.mdu_stall, 1);
      chk("wait_pulses", {m.mul_start, m.div_start, m.div_abort}, 0);
      n++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", n, is_div ? dl + 1 : MUL_LAT + 1);
    chk("done_result", {m.res_hi, m.res_lo}, exp);
    chk("done_stall", m.mdu_stall, 0);
    chk("done_we_idle", m.hilo_we, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #2;
      chk("hold_res_valid", m.res_valid, 1);
      chk("hold_we", m.hilo_we, 0);
      chk("hold_pulses", {m.mul_start, m.div_start}, 0);
    end
    m.exe_wr = 1'b1;
    #1;
    chk("commit_we", m.hilo_we, 1);
    chk("commit_result", {m.res_hi, m.res_lo}, exp);
    @(posedge clk); #1;
    m.exe_wr = 1'b0; m.req_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          dl, hold;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 1, 5, 64'hFFFFFFFF_FFFFFFFE};
    vecs[1]  = '{3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 1, 0, 64'h00000001_00000000};
    vecs[2]  = '{3'd3, 32'd7, 32'd2, 32'd0, 32'd0, 33, 1, 64'h00000001_00000003};
    vecs[3]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1, 2, 64'hFFFFFFFE_00000001};
    vecs[4]  = '{3'd6, 32'd3, 32'd4, 32'd0, 32'd0, 1, 0, 64'hFFFFFFFF_FFFFFFF4};
    vecs[5]  = '{3'd7, 32'd2, 32'd3, 32'd0, 32'd5, 1, 0, 64'hFFFFFFFF_FFFFFFFF};
    vecs[6]  = '{3'd4, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFF_FFFFFFF9};
    vecs[7]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 5, 0, 64'hFFFFFFFF_FFFFFFFD};
    vecs[8]  = '{3'd3, 32'd9, 32'd0, 32'd0, 32'd0, 3, 0, 64'h00000009_FFFFFFFF};
    vecs[9]  = '{3'd2, 32'd100, 32'd7, 32'd0, 32'd0, 1, 0, 64'h00000002_0000000E};
    vecs[10] = '{3'd0, 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0, 1, 0, 64'hFFFFFFFF_FFFFFFEB};
    rst = 1'b1;
    m.req_valid = 1'b1; m.req_op = 3'd0; m.req_a = 32'h12345678; m.req_b = 32'h9ABCDEF0;
    m.hi_in = 32'h1; m.lo_in = 32'h2; m.flush = 1'b0; m.exe_wr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", m.mdu_stall, 0);
    chk("rst_pulses", {m.mul_start, m.div_start, m.div_abort}, 0);
    chk("rst_res_valid", m.res_valid, 0);
    chk("rst_we", m.hilo_we, 0);
    chk("rst_result", {m.res_hi, m.res_lo}, 0);
    chk("rst_opnd", {m.mul_a, m.mul_b}, 0);
    chk("rst_sign", {m.mul_signed, m.div_signed}, 0);
    rst = 1'b0; m.req_valid = 1'b0; m.exe_wr = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dl, vecs[i].hold, -1, 1'b0, vecs[i].exp);
    run_op(3'd3, 32'd7, 32'd2, 32'd0, 32'd0, 33, 0, 10, 1'b0, 64'd0);
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    #1;
    chk("stray_done_ignored", m.res_valid, 0);
    run_op(3'd0, 32'd5, 32'd6, 32'd0, 32'd0, 1, 0, MUL_LAT, 1'b0, 64'd0);
    run_op(3'd4, 32'd5, 32'd6, 32'd1, 32'd1, 1, 0, 1, 1'b1, 64'd0);
    run_op(3'd2, 32'd50, 32'd5, 32'd0, 32'd0, 4, 0, 4, 1'b1, 64'd0);
    run_op(3'd1, 32'd3, 32'd3, 32'd0, 32'd0, 1, 0, -1, 1'b0, 64'd9);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] a, b, hi, lo;
      int dl, fl;
      bit is_div;
      op = 3'($urandom_range(0, 7));
      is_div = op == 3'd2 || op == 3'd3;
      a = $urandom;
      b = is_div ? 32'($urandom_range(1, 1000)) : $urandom;
      hi = $urandom; lo = $urandom;
      dl = $urandom_range(1, 12);
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, is_div ? dl : MUL_LAT) : -1;
      run_op(op, a, b, hi, lo, dl, $urandom_range(0, 3), fl, 1'($urandom_range(0, 1)), ref_res(op, a, b, hi, lo));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
